// File: rtl/serial_pad_poller.sv
// serial_pad_poller: shared latch/clock poller for NES/SNES-style serial pads with auto-poll and edge flags
module serial_pad_poller #(
    parameter int NUM_CONTROLLERS   = 4,
    parameter int NUM_BITS          = 8,
    parameter int LATCH_PULSE_WIDTH = 2,
    parameter int CLK_HALF_PERIOD   = 1,
    parameter int AUTO_POLL_PERIOD  = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_fetch_i,
    output logic                                  busy_o,
    output logic                                  valid_o,
    output logic                                  controller_clk_o,
    output logic                                  controller_latch_o,
    input  logic [NUM_CONTROLLERS-1:0]            controller_serial_LIST_ni,
    output logic [NUM_CONTROLLERS*NUM_BITS-1:0]   data_LIST_o,
    output logic [NUM_CONTROLLERS*NUM_BITS-1:0]   pressed_LIST_o,
    output logic [NUM_CONTROLLERS*NUM_BITS-1:0]   released_LIST_o
);
    localparam int W   = NUM_CONTROLLERS * NUM_BITS;
    localparam int PHW = $clog2((LATCH_PULSE_WIDTH > CLK_HALF_PERIOD ? LATCH_PULSE_WIDTH : CLK_HALF_PERIOD) + 1);
    localparam int BW  = $clog2(NUM_BITS);
    localparam int APW = AUTO_POLL_PERIOD > 1 ? $clog2(AUTO_POLL_PERIOD) : 1;
    localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_PULSE_WIDTH - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(CLK_HALF_PERIOD - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(NUM_BITS - 1);
    localparam logic [APW-1:0] POLL_LAST  = APW'(AUTO_POLL_PERIOD > 0 ? AUTO_POLL_PERIOD - 1 : 0);
    localparam bit             AUTO_EN    = AUTO_POLL_PERIOD > 0;

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [PHW-1:0] r_phase;
    logic [BW-1:0]  r_bit;
    logic [APW-1:0] r_poll;
    logic [W-1:0]   r_shift, w_shift, r_data, r_pressed, r_released;
    logic           w_start, w_sample;

    always_comb begin
        w_start  = start_fetch_i || (AUTO_EN && r_poll == POLL_LAST);
        w_sample = r_state == S_LOW && r_phase == HALF_LAST;
        w_next   = r_state;
        unique case (r_state)
            S_IDLE:  w_next = w_start ? S_LATCH : S_IDLE;
            S_LATCH: w_next = r_phase == LATCH_LAST ? S_LOW : S_LATCH;
            S_LOW:   w_next = w_sample ? (r_bit == BIT_LAST ? S_DONE : S_HIGH) : S_LOW;
            S_HIGH:  w_next = r_phase == HALF_LAST ? S_LOW : S_HIGH;
            default: w_next = S_IDLE;
        endcase
        // pads drive active-low data; bit k of every pad lands at slice bit k
        w_shift = r_shift;
        for (int p = 0; p < NUM_CONTROLLERS; p++)
            w_shift[p*NUM_BITS + int'(r_bit)] = ~controller_serial_LIST_ni[p];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_bit      <= '0;
            r_poll     <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            r_state <= w_next;
            r_phase <= (w_next == r_state && r_state != S_IDLE) ? r_phase + 1'b1 : '0;
            r_bit   <= r_state == S_IDLE ? '0 : (r_state == S_HIGH && w_next == S_LOW) ? r_bit + 1'b1 : r_bit;
            // saturating poll counter lets an expiry during a frame fire on the first idle cycle
            r_poll  <= (r_state == S_IDLE && w_start) ? '0 : (!AUTO_EN || r_poll == POLL_LAST) ? r_poll : r_poll + 1'b1;
            if (w_sample)
                r_shift <= w_shift;
            if (w_sample && r_bit == BIT_LAST) begin
                r_data     <= w_shift;
                r_pressed  <= w_shift & ~r_data;
                r_released <= ~w_shift & r_data;
            end
        end
    end

    assign busy_o             = r_state != S_IDLE;
    assign valid_o            = r_state == S_DONE;
    assign controller_latch_o = r_state == S_LATCH;
    assign controller_clk_o   = r_state == S_HIGH;
    assign data_LIST_o        = r_data;
    assign pressed_LIST_o     = r_pressed;
    assign released_LIST_o    = r_released;
endmodule

// File: tb/tb_serial_pad_poller.sv
// tb_serial_pad_poller: pad-model based bench covering default, SNES-timing and auto-poll configurations
module tb_serial_pad_poller;
    localparam int LAT_A = 2 + 1 * (2 * 8 - 1) + 1;
    localparam int LAT_B = 4 + 3 * (2 * 16 - 1) + 1;

    logic clk = 0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    logic        rst_a = 0, st_a = 0, busy_a, val_a, ck_a, la_a;
    logic [3:0]  ser_a;
    logic [31:0] d_a, p_a, r_a;
    logic        rst_b = 0, st_b = 0, busy_b, val_b, ck_b, la_b;
    logic [1:0]  ser_b;
    logic [31:0] d_b, p_b, r_b;
    logic        rst_cd = 0, st_c = 0, st_d = 0;
    logic        busy_c, val_c, ck_c, la_c, busy_d, val_d, ck_d, la_d;
    logic [0:0]  ser_c, ser_d;
    logic [7:0]  d_c, p_c, r_c, d_d, p_d, r_d;

    serial_pad_poller dut_a (
        .clk(clk), .rst_n(rst_a), .start_fetch_i(st_a), .busy_o(busy_a), .valid_o(val_a),
        .controller_clk_o(ck_a), .controller_latch_o(la_a), .controller_serial_LIST_ni(ser_a),
        .data_LIST_o(d_a), .pressed_LIST_o(p_a), .released_LIST_o(r_a));
    serial_pad_poller #(.NUM_CONTROLLERS(2), .NUM_BITS(16), .LATCH_PULSE_WIDTH(4), .CLK_HALF_PERIOD(3)) dut_b (
        .clk(clk), .rst_n(rst_b), .start_fetch_i(st_b), .busy_o(busy_b), .valid_o(val_b),
        .controller_clk_o(ck_b), .controller_latch_o(la_b), .controller_serial_LIST_ni(ser_b),
        .data_LIST_o(d_b), .pressed_LIST_o(p_b), .released_LIST_o(r_b));
    serial_pad_poller #(.NUM_CONTROLLERS(1), .AUTO_POLL_PERIOD(40)) dut_c (
        .clk(clk), .rst_n(rst_cd), .start_fetch_i(st_c), .busy_o(busy_c), .valid_o(val_c),
        .controller_clk_o(ck_c), .controller_latch_o(la_c), .controller_serial_LIST_ni(ser_c),
        .data_LIST_o(d_c), .pressed_LIST_o(p_c), .released_LIST_o(r_c));
    serial_pad_poller #(.NUM_CONTROLLERS(1), .AUTO_POLL_PERIOD(10)) dut_d (
        .clk(clk), .rst_n(rst_cd), .start_fetch_i(st_d), .busy_o(busy_d), .valid_o(val_d),
        .controller_clk_o(ck_d), .controller_latch_o(la_d), .controller_serial_LIST_ni(ser_d),
        .data_LIST_o(d_d), .pressed_LIST_o(p_d), .released_LIST_o(r_d));

    // pad models: latch reloads the button register, each rising pad clock advances to the next button
    logic [7:0]  pad_a[4];
    logic [15:0] pad_b[2];
    logic [7:0]  pad_c = 8'h5A, pad_d = 8'hC3;
    int   cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;
    logic pk_a = 0, pk_b = 0, pk_c = 0, pk_d = 0;
    always @(posedge clk) begin
        pk_a <= ck_a; cnt_a <= la_a ? 0 : (ck_a && !pk_a) ? cnt_a + 1 : cnt_a;
        pk_b <= ck_b; cnt_b <= la_b ? 0 : (ck_b && !pk_b) ? cnt_b + 1 : cnt_b;
        pk_c <= ck_c; cnt_c <= la_c ? 0 : (ck_c && !pk_c) ? cnt_c + 1 : cnt_c;
        pk_d <= ck_d; cnt_d <= la_d ? 0 : (ck_d && !pk_d) ? cnt_d + 1 : cnt_d;
    end
    always_comb begin
        for (int p = 0; p < 4; p++) ser_a[p] = ~pad_a[p][cnt_a[2:0]];
        for (int p = 0; p < 2; p++) ser_b[p] = ~pad_b[p][cnt_b[3:0]];
        ser_c[0] = ~pad_c[cnt_c[2:0]];
        ser_d[0] = ~pad_d[cnt_d[2:0]];
    end

    int run_b = 0;
    int hi_b[$];
    always @(posedge clk)
        if (ck_b) run_b <= run_b + 1;
        else if (run_b > 0) begin
            hi_b.push_back(run_b);
            run_b <= 0;
        end

    int r0 = 0, nva = 0;
    int vt_c[$], vt_d[$];
    logic [7:0] vd_c[$], vd_d[$];
    always @(negedge clk) begin
        if (val_a) nva <= nva + 1;
        if (val_c) begin vt_c.push_back(cyc - r0); vd_c.push_back(d_c); end
        if (val_d) begin vt_d.push_back(cyc - r0); vd_d.push_back(d_d); end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] old_a = 0;

    task automatic frame_a();
        int s, t;
        logic [31:0] e;
        e = {pad_a[3], pad_a[2], pad_a[1], pad_a[0]};
        @(posedge clk); #1 st_a = 1; s = cyc;
        @(posedge clk); #1 st_a = 0;
        t = -1;
        for (int i = 0; i < 100 && t < 0; i++) begin
            @(negedge clk);
            if (val_a) t = cyc;
        end
        chk("a_latency", t - s, LAT_A);
        chk("a_clk_pulses", cnt_a, 7);
        chk("a_data", d_a, e);
        chk("a_pressed", p_a, e & ~old_a);
        chk("a_released", r_a, ~e & old_a);
        old_a = e;
        @(posedge clk);
    endtask

    // expected valid cycles from the auto-poll rule: next start no earlier than period after the last one,
    // and never before the idle cycle following DONE
    task automatic check_auto(input string tag, input int period, input int vt[$], input logic [7:0] vd[$],
                              input logic [7:0] pad);
        int st, n, v;
        st = period - 1;
        n = 0;
        while (st + LAT_A < 150) begin
            v = st + LAT_A;
            if (n < vt.size()) begin
                chk({tag, "_valid_cycle"}, vt[n], v);
                chk({tag, "_data"}, vd[n], pad);
            end
            n++;
            st = (v + 1 > st + period) ? v + 1 : st + period;
        end
        chk({tag, "_frame_count"}, vt.size(), n);
    endtask

    initial begin
        int s, t, t1, t2, nv0;
        bit found;
        for (int p = 0; p < 4; p++) pad_a[p] = 8'h00;
        pad_b[0] = 16'hA5C3;
        pad_b[1] = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", val_a, 0);
        chk("rst_clk", ck_a, 0);
        chk("rst_latch", la_a, 0);
        chk("rst_data", d_a, 0);
        chk("rst_pressed", p_a, 0);
        chk("rst_released", r_a, 0);
        @(posedge clk); #1 rst_a = 1; rst_b = 1; rst_cd = 1; r0 = cyc;

        while (cyc - r0 < 45) @(posedge clk);
        #1 st_c = 1;
        @(posedge clk); #1 st_c = 0;
        while (cyc - r0 < 150) @(posedge clk);
        check_auto("c", 40, vt_c, vd_c, pad_c);
        check_auto("d", 10, vt_d, vd_d, pad_d);
        #1 rst_cd = 0;

        for (int v = 0; v < 256; v++) begin
            pad_a[0] = 8'(v);
            for (int p = 1; p < 4; p++) pad_a[p] = 8'($urandom);
            frame_a();
        end

        pad_a[0] = 8'h0F; frame_a();
        pad_a[0] = 8'h3C; frame_a();
        chk("a_pressed_3c", p_a[7:0], 8'h30);
        chk("a_released_3c", r_a[7:0], 8'h03);
        frame_a();
        chk("a_pressed_same", p_a[7:0], 8'h00);
        chk("a_released_same", r_a[7:0], 8'h00);

        @(posedge clk); #1 st_a = 1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 100 && t1 < 0; i++) begin @(negedge clk); if (val_a) t1 = cyc; end
        for (int i = 0; i < 100 && t2 < 0; i++) begin @(negedge clk); if (val_a) t2 = cyc; end
        chk("a_back_to_back_gap", t2 - t1, LAT_A + 1);
        @(posedge clk); #1 st_a = 0;
        for (int i = 0; i < 100 && busy_a; i++) @(negedge clk);
        chk("a_idle_after_hold", busy_a, 0);

        for (int p = 0; p < 4; p++) pad_a[p] = 8'($urandom);
        @(posedge clk); #1 st_a = 1;
        @(posedge clk); #1 st_a = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (busy_a && !la_a && !ck_a && cnt_a == 4) found = 1;
        end
        chk("a_reached_low4", found, 1);
        rst_a = 0;
        @(posedge clk); #1 rst_a = 1;
        @(negedge clk);
        chk("abort_busy", busy_a, 0);
        chk("abort_latch", la_a, 0);
        chk("abort_clk", ck_a, 0);
        chk("abort_valid", val_a, 0);
        chk("abort_data", d_a, 0);
        chk("abort_pressed", p_a, 0);
        chk("abort_released", r_a, 0);
        nv0 = nva;
        repeat (30) @(negedge clk);
        chk("abort_no_valid", nva - nv0, 0);
        old_a = 0;
        for (int p = 0; p < 4; p++) pad_a[p] = 8'($urandom);
        frame_a();

        @(posedge clk); #1 st_b = 1; s = cyc;
        @(posedge clk); #1 st_b = 0;
        t = -1;
        for (int i = 0; i < 200 && t < 0; i++) begin @(negedge clk); if (val_b) t = cyc; end
        chk("b_latency", t - s, LAT_B);
        chk("b_data", d_b, {pad_b[1], pad_b[0]});
        chk("b_pressed", p_b, {pad_b[1], pad_b[0]});
        chk("b_released", r_b, 0);
        chk("b_clk_pulses", cnt_b, 15);
        chk("b_high_phase_count", hi_b.size(), 15);
        foreach (hi_b[i]) chk("b_high_width", hi_b[i], 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
